// File: rtl/seg_frame_capture.sv
// Recovers BCD digits from a multiplexed active-low 7-segment bus and emits whole frames on valid/ready.
// Optional SEG_FRAME_CAPTURE_DP_EN adds decimal-point capture on the frame_dp port.
module seg_frame_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   frame_bcd,
  output logic [DIGITS-1:0]     frame_err,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun
`ifdef SEG_FRAME_CAPTURE_DP_EN
  ,
  output logic [DIGITS-1:0]     frame_dp
`endif
);

`ifdef SEG_FRAME_CAPTURE_DP_EN
  localparam int SW = 8;
`else
  localparam int SW = 7;
  // DP line is deliberately unobserved in this build.
  logic unused_dp;
  assign unused_dp = seg_in[7];
`endif

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [SW-1:0]     seg_s1, seg_s2, seg_prev;
  logic [DIGITS-1:0] an_s1, an_s2, an_prev;
  logic [7:0]        cnt, cnt_next;
  logic              latched, latched_next;
  logic [DIGITS-1:0] an_inv;
  logic              an_ok, same, accept;
  logic [IW-1:0]     dig_idx;
  logic [4:0]        dec_out;

  logic [3:0]        slot_bcd [DIGITS];
  logic [DIGITS-1:0] slot_err;
  logic [DIGITS-1:0] seen;
  logic [DIGITS-1:0] hit;
  logic [4*DIGITS-1:0] slot_flat;
  logic              complete, load, drop, transfer;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   return 5'h00;
      7'h79:   return 5'h01;
      7'h24:   return 5'h02;
      7'h30:   return 5'h03;
      7'h19:   return 5'h04;
      7'h12:   return 5'h05;
      7'h02:   return 5'h06;
      7'h78:   return 5'h07;
      7'h00:   return 5'h08;
      7'h10:   return 5'h09;
      7'h7F:   return 5'h0F;
      default: return 5'h1E;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      an_s1  <= '0;
      an_s2  <= '0;
    end else begin
      seg_s1 <= seg_in[SW-1:0];
      seg_s2 <= seg_s1;
      an_s1  <= an_in;
      an_s2  <= an_s1;
    end
  end

  always_comb begin
    an_inv  = ~an_s2;
    an_ok   = (an_inv != '0) && ((an_inv & (an_inv - 1'b1)) == '0);
    dig_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_s2[i]) dig_idx = IW'(i);
    end
    same = (an_s2 == an_prev) && (seg_s2 == seg_prev);
    if (!an_ok)
      cnt_next = 8'd0;
    else if (same)
      cnt_next = (cnt == STABLE) ? cnt : cnt + 8'd1;
    else
      cnt_next = 8'd1;
    accept = an_ok && (cnt_next == STABLE) && !latched;
    // The flag survives segment changes within a phase; only an anode change re-arms it.
    latched_next = (an_ok && (an_s2 == an_prev) && latched) || accept;
    dec_out = decode(seg_s2[6:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_prev <= '0;
      an_prev  <= '0;
      cnt      <= '0;
      latched  <= 1'b0;
    end else begin
      seg_prev <= seg_s2;
      an_prev  <= an_s2;
      cnt      <= cnt_next;
      latched  <= latched_next;
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_slot
    assign hit[gi] = accept && (dig_idx == IW'(gi));
    assign slot_flat[4*gi +: 4] = slot_bcd[gi];
  end

  assign complete = &seen;
  assign transfer = frame_valid && frame_ready;
  assign load     = complete && (!frame_valid || frame_ready);
  assign drop     = complete && frame_valid && !frame_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DIGITS; i++) slot_bcd[i] <= 4'h0;
      slot_err <= '0;
      seen     <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (hit[i]) begin
          slot_bcd[i] <= dec_out[3:0];
          slot_err[i] <= dec_out[4];
          seen[i]     <= 1'b1;
        end else if (complete) begin
          seen[i]     <= 1'b0;
        end
      end
    end
  end

`ifdef SEG_FRAME_CAPTURE_DP_EN
  logic [DIGITS-1:0] slot_dp;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_dp  <= '0;
      frame_dp <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (hit[i]) slot_dp[i] <= ~seg_s2[7];
      end
      if (load) frame_dp <= slot_dp;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_bcd   <= '0;
      frame_err   <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (load) begin
        frame_bcd   <= slot_flat;
        frame_err   <= slot_err;
        frame_valid <= 1'b1;
      end else if (transfer) begin
        frame_valid <= 1'b0;
      end
      if (drop)
        overrun <= 1'b1;
      else if (transfer)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_frame_capture.sv
// Directed bench for seg_frame_capture: scans are driven in one initial block, expected frames are
// queued as scans are issued and checked when the DUT hands them over.
module tb_seg_frame_capture;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] frame_bcd;
  logic [3:0]  frame_err;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;
`ifdef SEG_FRAME_CAPTURE_DP_EN
  logic [3:0]  frame_dp;
`endif

  seg_frame_capture #(.DIGITS(4), .STABLE_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .frame_bcd   (frame_bcd),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun)
`ifdef SEG_FRAME_CAPTURE_DP_EN
    ,
    .frame_dp    (frame_dp)
`endif
  );

  always #5 clk = ~clk;

  // Segment bytes with the DP line off (bit 7 high).
  localparam logic [7:0] S0 = 8'hC0, S1 = 8'hF9, S2 = 8'hA4, S3 = 8'hB0, S4 = 8'h99;
  localparam logic [7:0] S5 = 8'h92, S6 = 8'h82, S7 = 8'hF8, S8 = 8'h80, S9 = 8'h90;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  err;
    logic [3:0]  dp;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int total = 0;
  int bad   = 0;

  task automatic push_exp(input logic [15:0] b, input logic [3:0] e, input logic [3:0] d);
    exp_t x;
    x.bcd = b; x.err = e; x.dp = d;
    q.push_back(x);
  endtask

  // Wait n cycles and realign to 3 time units after the rising edge.
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic phase(input int d, input logic [7:0] s);
    an_in  = ~(4'b0001 << d);
    seg_in = s;
    hold(64);
    an_in  = 4'hF;
    hold(4);
  endtask

  task automatic scan(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    phase(0, a);
    phase(1, b);
    phase(2, c);
    phase(3, d);
  endtask

  // Scoreboard side: every handover is checked against the oldest queued frame.
  always @(negedge clk) begin
    if (!reset && frame_valid && frame_ready) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_frame got=%h want=none", frame_bcd);
      end
      if (q.size() != 0) begin
        cur = q.pop_front();
        total++;
        assert (frame_bcd === cur.bcd) else begin
          bad++;
          $error("FAIL frame_bcd got=%h want=%h", frame_bcd, cur.bcd);
        end
        total++;
        assert (frame_err === cur.err) else begin
          bad++;
          $error("FAIL frame_err got=%b want=%b", frame_err, cur.err);
        end
`ifdef SEG_FRAME_CAPTURE_DP_EN
        total++;
        assert (frame_dp === cur.dp) else begin
          bad++;
          $error("FAIL frame_dp got=%b want=%b", frame_dp, cur.dp);
        end
`endif
      end
    end
  end

  initial begin
    reset       = 1'b1;
    seg_in      = 8'hFF;
    an_in       = 4'hF;
    frame_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    total++; assert (frame_valid === 1'b0) else begin bad++; $error("FAIL rst_valid got=%b want=0", frame_valid); end
    total++; assert (frame_bcd === 16'h0) else begin bad++; $error("FAIL rst_bcd got=%h want=0000", frame_bcd); end
    total++; assert (frame_err === 4'h0) else begin bad++; $error("FAIL rst_err got=%b want=0000", frame_err); end
    total++; assert (overrun === 1'b0) else begin bad++; $error("FAIL rst_overrun got=%b want=0", overrun); end
    reset = 1'b0;
    hold(2);

    // Basic capture, two scans -> two frames.
    push_exp(16'h4321, 4'b0000, 4'b0000);
    scan(S1, S2, S3, S4);
    push_exp(16'h4321, 4'b0000, 4'b0000);
    scan(S1, S2, S3, S4);

    // Glitch on digit 0: short "2" must never be accepted.
    push_exp(16'h8763, 4'b0000, 4'b0000);
    an_in = 4'b1110; seg_in = S2; hold(10);
    seg_in = S3; hold(40);
    an_in = 4'hF; hold(4);
    phase(1, S6);
    phase(2, S7);
    phase(3, S8);

    // Unrecognised pattern on digit 2, blank on digit 3.
    push_exp(16'hFE21, 4'b0100, 4'b0000);
    scan(S1, S2, 8'hFE, 8'hFF);

    // Backpressure: first frame held, second dropped.
    frame_ready = 1'b0;
    push_exp(16'h5678, 4'b0000, 4'b0000);
    scan(S8, S7, S6, S5);
    scan(S0, S0, S0, S0);
    total++; assert (frame_valid === 1'b1) else begin bad++; $error("FAIL bp_valid got=%b want=1", frame_valid); end
    total++; assert (frame_bcd === 16'h5678) else begin bad++; $error("FAIL bp_hold got=%h want=5678", frame_bcd); end
    total++; assert (overrun === 1'b1) else begin bad++; $error("FAIL bp_overrun got=%b want=1", overrun); end
    frame_ready = 1'b1;
    hold(3);
    total++; assert (overrun === 1'b0) else begin bad++; $error("FAIL bp_overrun_clr got=%b want=0", overrun); end
    total++; assert (frame_valid === 1'b0) else begin bad++; $error("FAIL bp_valid_clr got=%b want=0", frame_valid); end

    // Reset after two digits; stale slots must not leak into the next frame.
    phase(0, S5);
    phase(1, S6);
    reset = 1'b1;
    #1;
    total++; assert (frame_bcd === 16'h0) else begin bad++; $error("FAIL mid_rst_bcd got=%h want=0000", frame_bcd); end
    total++; assert (frame_valid === 1'b0) else begin bad++; $error("FAIL mid_rst_valid got=%b want=0", frame_valid); end
    hold(2);
    reset = 1'b0;
    hold(2);
    push_exp(16'h8709, 4'b0000, 4'b0000);
    phase(2, S7);
    phase(3, S8);
    phase(0, S9);
    phase(1, S0);

    // Decimal point on digit 1 (bit 7 low).
    push_exp(16'h0213, 4'b0000, 4'b0010);
    scan(S3, 8'h79, S2, S0);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    #3;
    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL frames_pending got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
